// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings for the decode-stage control unit: instruction modes, opcodes,
// ALU commands and ARM condition codes.
package pipelined_control_unit_pkg;

  typedef enum logic [1:0] {
    ModeArith  = 2'b00,
    ModeMem    = 2'b01,
    ModeBranch = 2'b10,
    ModeRsvd   = 2'b11
  } mode_e;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef enum logic [3:0] {
    CmdNop = 4'b0000,
    CmdMov = 4'b0001,
    CmdAdd = 4'b0010,
    CmdAdc = 4'b0011,
    CmdSub = 4'b0100,
    CmdSbc = 4'b0101,
    CmdAnd = 4'b0110,
    CmdOrr = 4'b0111,
    CmdEor = 4'b1000,
    CmdMvn = 4'b1001
  } alu_cmd_e;

  typedef enum logic [3:0] {
    CondEq = 4'b0000, CondNe = 4'b0001, CondCs = 4'b0010, CondCc = 4'b0011,
    CondMi = 4'b0100, CondPl = 4'b0101, CondVs = 4'b0110, CondVc = 4'b0111,
    CondHi = 4'b1000, CondLs = 4'b1001, CondGe = 4'b1010, CondLt = 4'b1011,
    CondGt = 4'b1100, CondLe = 4'b1101, CondAl = 4'b1110, CondNv = 4'b1111
  } cond_e;

endpackage

// File: rtl/pipelined_control_unit_cond_check.sv
// Combinational ARM condition-code evaluation against the current {N,Z,C,V}.
module pipelined_control_unit_cond_check
  import pipelined_control_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] status_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = status_i;

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      CondEq:  pass_o = z;
      CondNe:  pass_o = !z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = !c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = !n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = !v;
      CondHi:  pass_o = c & !z;
      CondLs:  pass_o = !c | z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = !z & (n == v);
      CondLe:  pass_o = z | (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode-stage control unit: decodes the IF/ID instruction into a registered ID/EX control
// word, with condition evaluation, status-flag hazard interlock and branch-shadow squashing.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int unsigned CMD_W         = 4,
  parameter int unsigned FLAG_LAT      = 1,
  parameter int unsigned BRANCH_SHADOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       cond,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic [3:0]       status_in,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [CMD_W-1:0] exec_cmd,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             s_out,
  output logic             b,
  output logic             illegal_out
);

  alu_cmd_e dec_cmd;
  logic dec_mr, dec_mw, dec_wb, dec_s, dec_b, dec_ill;

  always_comb begin
    dec_cmd = CmdNop;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wb  = 1'b0;
    dec_s   = 1'b0;
    dec_b   = 1'b0;
    dec_ill = 1'b0;
    case (mode_e'(mode))
      ModeArith: begin
        dec_wb = 1'b1;
        dec_s  = s_in;
        case (op_code)
          OpMov: dec_cmd = CmdMov;
          OpMvn: dec_cmd = CmdMvn;
          OpAdd: dec_cmd = CmdAdd;
          OpAdc: dec_cmd = CmdAdc;
          OpSub: dec_cmd = CmdSub;
          OpSbc: dec_cmd = CmdSbc;
          OpAnd: dec_cmd = CmdAnd;
          OpOrr: dec_cmd = CmdOrr;
          OpEor: dec_cmd = CmdEor;
          OpCmp: begin dec_cmd = CmdSub; dec_wb = 1'b0; dec_s = 1'b1; end
          OpTst: begin dec_cmd = CmdAnd; dec_wb = 1'b0; dec_s = 1'b1; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; dec_ill = 1'b1; end
        endcase
      end
      ModeMem: begin
        dec_cmd = CmdAdd;
        dec_mr  = s_in;
        dec_mw  = !s_in;
        dec_wb  = s_in;
      end
      ModeBranch: dec_b = 1'b1;
      default:    dec_ill = 1'b1;
    endcase
  end

  logic pass;
  pipelined_control_unit_cond_check u_cond_check (
    .cond_i   (cond),
    .status_i (status_in),
    .pass_o   (pass)
  );

  logic [1:0] pend_q, pend_d, shd_q, shd_d;
  logic       pend_busy, shd_busy, hazard, accept, squash, issue;

  assign pend_busy = (pend_q != 2'd0);
  assign shd_busy  = (shd_q != 2'd0);
  // A squashed instruction never executes, so it cannot be a flag hazard.
  assign hazard    = valid_in & (cond != CondAl) & pend_busy & !shd_busy;
  assign ready_out = !stall_in & !hazard;
  assign accept    = valid_in & ready_out & !flush_in;
  assign squash    = accept & shd_busy;
  assign issue     = accept & !squash & pass & !dec_ill;

  logic             valid_q, valid_d, mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;
  logic             s_q, s_d, b_q, b_d, ill_q, ill_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;

  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    wb_d    = wb_q;
    s_d     = s_q;
    b_d     = b_q;
    ill_d   = 1'b0;
    pend_d  = pend_q;
    shd_d   = shd_q;
    if (flush_in) begin
      valid_d = 1'b0;
      cmd_d   = '0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      wb_d    = 1'b0;
      s_d     = 1'b0;
      b_d     = 1'b0;
      shd_d   = 2'd0;
    end else if (!stall_in) begin
      valid_d = issue;
      cmd_d   = issue ? CMD_W'(dec_cmd) : '0;
      mr_d    = issue & dec_mr;
      mw_d    = issue & dec_mw;
      wb_d    = issue & dec_wb;
      s_d     = issue & dec_s;
      b_d     = issue & dec_b;
      ill_d   = accept & !squash & dec_ill;
      if (issue && dec_s) pend_d = 2'(FLAG_LAT);
      else if (pend_busy) pend_d = pend_q - 2'd1;
      if (squash)              shd_d = shd_q - 2'd1;
      else if (issue && dec_b) shd_d = 2'(BRANCH_SHADOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      wb_q    <= 1'b0;
      s_q     <= 1'b0;
      b_q     <= 1'b0;
      ill_q   <= 1'b0;
      pend_q  <= 2'd0;
      shd_q   <= 2'd0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      wb_q    <= wb_d;
      s_q     <= s_d;
      b_q     <= b_d;
      ill_q   <= ill_d;
      pend_q  <= pend_d;
      shd_q   <= shd_d;
    end
  end

  assign valid_out   = valid_q;
  assign exec_cmd    = cmd_q;
  assign mem_r_en    = mr_q;
  assign mem_w_en    = mw_q;
  assign wb_en       = wb_q;
  assign s_out       = s_q;
  assign b           = b_q;
  assign illegal_out = ill_q;

endmodule
